div_issue_ctrl: RTL and testbench

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

---
 rtl/div_issue_ctrl_if.sv | 45 ++++
 rtl/div_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl_if
// Brief    : Decode, divider and writeback signals of the divide issue block.
// Revision : 1.0 - initial release
// ============================================================================
interface div_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        flush;

    logic        div_start;
    logic [4:0]  div_op_sel;
    logic [31:0] div_rs1;
    logic [31:0] div_rs2;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;

    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, flush,
               div_busy, div_done, div_result, out_ready,
        input  in_ready, div_start, div_op_sel, div_rs1, div_rs2,
               out_valid, out_rd, out_data, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, flush,
               div_busy, div_done, div_result, out_ready,
        output in_ready, div_start, div_op_sel, div_rs1, div_rs2,
               out_valid, out_rd, out_data, out_err
    );
endinterface
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Brief    : Issues one divide/remainder op to an iterative divider and holds
//            the result (or a timeout/illegal-op error) for writeback.
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int DIV_TIMEOUT = 40
) (
    input  wire logic       clk,
    input  wire logic       rst,
    div_issue_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [5:0] c_TIMEOUT_CNT = 6'(DIV_TIMEOUT);
    localparam logic [5:0] c_CNT_MAX     = 6'h3F;

    state_t      r_state;
    logic        r_div_start;
    logic [4:0]  r_op;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic        r_out_valid;
    logic [4:0]  r_out_rd;
    logic [31:0] r_out_data;
    logic        r_out_err;
    logic [5:0]  r_cnt;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_op_ok;
    logic [5:0]  w_cnt_inc;
    logic        w_timeout;
    logic        w_unused;

    assign w_in_ready = (r_state == S_IDLE) && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;
    // DIV/DIVU/REM/REMU are exactly the 101xx opcodes
    assign w_op_ok    = (bus.in_op[4:2] == 3'b101);
    assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 6'd1;
    assign w_timeout  = (w_cnt_inc >= c_TIMEOUT_CNT);
    assign w_unused   = bus.div_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div_start <= 1'b0;
            r_op        <= 5'd0;
            r_rs1       <= 32'd0;
            r_rs2       <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_rd    <= 5'd0;
            r_out_data  <= 32'd0;
            r_out_err   <= 1'b0;
            r_cnt       <= 6'd0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= bus.in_op;
                        r_rs1    <= bus.in_rs1;
                        r_rs2    <= bus.in_rs2;
                        r_out_rd <= bus.in_rd;
                        if (w_op_ok) begin
                            r_state     <= S_ISSUE;
                            r_div_start <= 1'b1;
                        end else begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_out_data  <= 32'd0;
                            r_out_err   <= 1'b1;
                        end
                    end
                end
                // The start pulse is already out; a flush here must still
                // wait for the divider to finish.
                S_ISSUE: begin
                    r_cnt   <= 6'd0;
                    r_state <= bus.flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (bus.div_done || w_timeout) begin
                        if (bus.flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_out_data  <= bus.div_done ? bus.div_result : 32'd0;
                            r_out_err   <= !bus.div_done;
                        end
                    end else if (bus.flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready || bus.flush) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= w_cnt_inc;
                    if (bus.div_done || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.div_start  = r_div_start;
    assign bus.div_op_sel = r_op;
    assign bus.div_rs1    = r_rs1;
    assign bus.div_rs2    = r_rs2;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_rd     = r_out_rd;
    assign bus.out_data   = r_out_data;
    assign bus.out_err    = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_div_issue_ctrl
// Brief    : Directed bench with a transaction-level expectation queue and a
//            behavioural iterative-divider model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;
    localparam int         DIV_TIMEOUT = 40;
    localparam logic [4:0] OP_DIV  = 5'b10100;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b10110;
    localparam logic [4:0] OP_REMU = 5'b10111;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        logic        ready;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_err = 0;
    int          n_starts = 0;
    int          n_hs = 0;
    bit          inflight = 0;
    bit          start_due = 0;
    int          wcnt = 0;
    logic [4:0]  cur_op = '0;
    logic [31:0] cur_rs1 = '0;
    logic [31:0] cur_rs2 = '0;
    int          div_lat = 6;
    int          dcnt = 0;
    logic [31:0] dres = '0;
    bit          nxt_done = 0;
    bit          exp_rdy;
    bit          exp_ov;

    function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (op == OP_DIV) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return sa / sb;
        end
        if (op == OP_DIVU) return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        if (op == OP_REM) begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
        end
        return (b == 32'd0) ? a : a % b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_rd    = rd;
        step();
        bus.in_valid = 1'b0;
    endtask

    // k = cycles from the accept cycle to the first out_valid cycle
    task automatic wait_valid(input int max, output int k);
        k = 1;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) return;
            if (k >= max) begin
                n_chk++;
                n_err++;
                $display("FAIL wait_valid: out_valid actual=0 required=1 within %0d cycles", max);
                return;
            end
            k++;
        end
    endtask

    // Divider-side inputs change just after the rising edge.
    initial begin
        bus.div_done   = 1'b0;
        bus.div_result = 32'd0;
        bus.div_busy   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.div_done   = nxt_done;
            bus.div_result = nxt_done ? dres : 32'hDEAD_BEEF;
            bus.div_busy   = (dcnt > 0) || nxt_done;
        end
    end

    // Compare process: expectation queue of ops not yet handed to writeback.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                inflight  = 0;
                start_due = 0;
            end else begin
                exp_rdy = !bus.flush && (q.size() == 0) && !inflight;
                exp_ov  = (q.size() > 0) && q[0].ready;
                chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
                chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
                chk("div_start", 32'(bus.div_start), 32'(start_due));
                if (exp_ov) begin
                    chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
                    chk("out_data", bus.out_data, q[0].data);
                    chk("out_err", 32'(bus.out_err), 32'(q[0].err));
                end
                if (start_due || inflight) begin
                    chk("div_op_sel", 32'(bus.div_op_sel), 32'(cur_op));
                    chk("div_rs1", bus.div_rs1, cur_rs1);
                    chk("div_rs2", bus.div_rs2, cur_rs2);
                end
                if (bus.div_start === 1'b1) n_starts++;
                // The divider either answers within DIV_TIMEOUT waiting cycles or the op errors out.
                if (inflight) begin
                    if (bus.div_done === 1'b1 || wcnt + 1 >= DIV_TIMEOUT) begin
                        if (q.size() > 0 && !q[0].ready) begin
                            e = q[0];
                            e.ready = 1'b1;
                            if (bus.div_done !== 1'b1) begin
                                e.err  = 1'b1;
                                e.data = 32'd0;
                            end
                            q[0] = e;
                        end
                        inflight = 0;
                    end else begin
                        wcnt++;
                    end
                end
                if (start_due) begin
                    inflight = 1;
                    wcnt     = 0;
                end
                start_due = 0;
                if (exp_ov && bus.out_ready) begin
                    void'(q.pop_front());
                    n_hs++;
                end else if (bus.flush) begin
                    q.delete();
                end
                if (bus.in_valid && exp_rdy) begin
                    cur_op  = bus.in_op;
                    cur_rs1 = bus.in_rs1;
                    cur_rs2 = bus.in_rs2;
                    e.rd    = bus.in_rd;
                    if (bus.in_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
                        e.data    = ref_div(bus.in_op, bus.in_rs1, bus.in_rs2);
                        e.err     = 1'b0;
                        e.ready   = 1'b0;
                        start_due = 1;
                    end else begin
                        e.data  = 32'd0;
                        e.err   = 1'b1;
                        e.ready = 1'b1;
                    end
                    q.push_back(e);
                end
            end
            // Divider model: rs2==0 takes the 2-cycle fast path; div_lat==0 never answers.
            if (bus.div_start === 1'b1 && !rst) begin
                dres = ref_div(bus.div_op_sel, bus.div_rs1, bus.div_rs2);
                dcnt = (bus.div_rs2 == 32'd0) ? 2 : div_lat;
            end
            if (dcnt > 0) begin
                dcnt--;
                nxt_done = (dcnt == 0);
            end else begin
                nxt_done = 0;
            end
        end
    end

    initial begin : stim
        int k;
        int s0;
        int h0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 5'd0;
        bus.in_rs1    = 32'd0;
        bus.in_rs2    = 32'd0;
        bus.in_rd     = 5'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_div_start", 32'(bus.div_start), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_div_op_sel", 32'(bus.div_op_sel), 32'd0);
        step();
        rst = 1'b0;
        step();

        // DIV -7/2
        bus.out_ready = 1'b1;
        div_lat = 6;
        s0 = n_starts;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);
        wait_valid(20, k);
        chk("div_latency", k, 8);
        chk("div_data", bus.out_data, 32'hFFFF_FFFD);
        chk("div_rd", 32'(bus.out_rd), 32'd5);
        chk("div_err", 32'(bus.out_err), 32'd0);
        step();
        chk("div_start_count", n_starts - s0, 1);

        // DIVU by zero, issued back-to-back after the previous handshake
        issue(OP_DIVU, 32'h0000_1234, 32'd0, 5'd7);
        wait_valid(20, k);
        chk("divu0_latency", k, 4);
        chk("divu0_data", bus.out_data, 32'hFFFF_FFFF);
        chk("divu0_rd", 32'(bus.out_rd), 32'd7);
        step();

        // REM overflow case with a 5-cycle writeback stall
        bus.out_ready = 1'b0;
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        wait_valid(20, k);
        chk("rem_data", bus.out_data, 32'd0);
        h0 = n_hs;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_rd", 32'(bus.out_rd), 32'd12);
        end
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_release_valid", 32'(bus.out_valid), 32'd0);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        chk("stall_handshakes", n_hs - h0, 1);

        // Flush 10 cycles into WAIT
        step();
        bus.out_ready = 1'b1;
        div_lat = 20;
        issue(OP_DIV, 32'd100, 32'd7, 5'd3);
        repeat (10) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
            chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        @(negedge clk);
        chk("drain_done_in_ready", 32'(bus.in_ready), 32'd1);

        // Flush during ISSUE: start still goes out
        step();
        div_lat = 4;
        s0 = n_starts;
        issue(OP_REMU, 32'd50, 32'd7, 5'd8);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        repeat (8) step();
        chk("issue_flush_starts", n_starts - s0, 1);

        // Flush in HOLD drops the result
        bus.out_ready = 1'b0;
        div_lat = 3;
        issue(OP_DIVU, 32'd99, 32'd9, 5'd10);
        wait_valid(20, k);
        chk("divu_data", bus.out_data, 32'd11);
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("hold_flush_drop", 32'(bus.out_valid), 32'd0);

        // Flush with out_ready in HOLD: handshake wins
        step();
        h0 = n_hs;
        issue(OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd11);
        wait_valid(20, k);
        chk("div_neg_data", bus.out_data, 32'hFFFF_FFFA);
        step();
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_ready_handshake", n_hs - h0, 1);

        // in_valid together with flush in IDLE never accepts
        step();
        s0 = n_starts;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_DIV;
        bus.in_rs1   = 32'd9;
        bus.in_rs2   = 32'd3;
        bus.flush    = 1'b1;
        @(negedge clk);
        chk("idle_flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (3) step();
        chk("idle_flush_starts", n_starts - s0, 0);

        // Divider never answers
        bus.out_ready = 1'b1;
        div_lat = 0;
        issue(OP_DIVU, 32'd10, 32'd3, 5'd13);
        wait_valid(60, k);
        chk("timeout_latency", k, 42);
        chk("timeout_err", 32'(bus.out_err), 32'd1);
        chk("timeout_data", bus.out_data, 32'd0);
        chk("timeout_rd", 32'(bus.out_rd), 32'd13);
        step();

        // Illegal opcode completes at once with an error
        s0 = n_starts;
        issue(5'b00000, 32'd1, 32'd1, 5'd14);
        wait_valid(5, k);
        chk("illegal_latency", k, 1);
        chk("illegal_err", 32'(bus.out_err), 32'd1);
        chk("illegal_data", bus.out_data, 32'd0);
        step();
        chk("illegal_starts", n_starts - s0, 0);

        // Asynchronous reset in the middle of WAIT
        div_lat = 20;
        issue(OP_DIVU, 32'd1000, 32'd10, 5'd9);
        repeat (5) step();
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_div_start", 32'(bus.div_start), 32'd0);
        chk("arst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("arst_div_rs1", bus.div_rs1, 32'd0);
        chk("arst_div_rs2", bus.div_rs2, 32'd0);
        chk("arst_div_op_sel", 32'(bus.div_op_sel), 32'd0);
        step();
        step();
        rst = 1'b0;
        repeat (25) step();
        div_lat = 6;
        issue(OP_DIV, 32'd100, 32'd7, 5'd4);
        wait_valid(20, k);
        chk("post_rst_latency", k, 8);
        chk("post_rst_data", bus.out_data, 32'd14);
        chk("post_rst_rd", 32'(bus.out_rd), 32'd4);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
